min_max_tree_reducer: RTL

Parametrised, pipelined comparator tree. Each accepted vector of N unsigned W-bit operands is reduced to its minimum or maximum, together with the index of the winning operand. Mode is selectable per vector, and valid tags travel alongside the data. It is the general replacement for the fixed 4-input, 7-bit, min-only comparator stage. It sits between the fuzzy membership evaluators and the rule-aggregation logic.

---
 rtl/min_max_tree_reducer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/min_max_tree_reducer.sv
// ---------------------------------------------------------------------------
// min_max_tree_reducer
//
// Pipelined comparator tree. Each accepted vector of N unsigned W-bit
// operands is reduced to its minimum (io_mode = 0) or maximum (io_mode = 1).
// The index of the winning operand comes out with it. Level 1 pairs operands
// (0,1), (2,3), ... and every later level pairs the survivors in order. At a
// level with an odd count, the last element passes through a register, so
// every path is L = ceil(log2 N) levels deep. On equal values the left
// (lower-index) element wins, so ties always resolve to the lowest original
// index.
//
// Flow control: there is no ready signal. io_start is a global advance
// enable. While it is high, every level loads from the one before it and a
// vector is taken from io_inputs/io_mode/io_in_valid. A vector with
// io_in_valid = 0 travels as a bubble. While io_start is low, every register
// (including the valid bits) holds and the inputs are ignored.
//
// Ports:
//   clock        in   1     rising-edge clock
//   reset        in   1     asynchronous, active-high clear of all state
//   io_start     in   1     global advance enable
//   io_in_valid  in   1     operand vector valid (sampled when io_start = 1)
//   io_mode      in   1     0 = minimum, 1 = maximum (sampled with vector)
//   io_inputs    in   N*W   operand k at bits [k*W+W-1 : k*W]
//   io_result    out  W     winning operand value
//   io_index     out  IW    index of the winning operand
//   io_mode_out  out  1     mode the result was computed with
//   io_out_valid out  1     result/index/mode_out are valid
// ---------------------------------------------------------------------------
module min_max_tree_reducer #(
  parameter int N  = 4,
  parameter int W  = 7,
  parameter int IW = (N > 2) ? $clog2(N) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_start,
  input  logic            io_in_valid,
  input  logic            io_mode,
  input  logic [N*W-1:0]  io_inputs,
  output logic [W-1:0]    io_result,
  output logic [IW-1:0]   io_index,
  output logic            io_mode_out,
  output logic            io_out_valid
);

  localparam int L = $clog2(N);
  // Source arrays are twice as wide as N so that reading a pair partner
  // (2j+1) never leaves the array. Unused slots are tied to zero.
  localparam int M = 2 * N;

  // Number of live elements at a given level (level 0 = the raw operands).
  function automatic int cnt_at(input int lvl);
    int c;
    c = N;
    for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
    return c;
  endfunction

  // Pipeline registers, levels 1..L.
  logic [W-1:0]  r_val  [1:L][0:N-1];
  logic [IW-1:0] r_idx  [1:L][0:N-1];
  logic          r_mode [1:L][0:N-1];
  logic          r_vld  [1:L][0:N-1];

  // Source view for each level's comparators: level 0 is the input port,
  // level l (1..L-1) is the register bank of level l.
  logic [W-1:0]  w_val  [0:L-1][0:M-1];
  logic [IW-1:0] w_idx  [0:L-1][0:M-1];
  logic          w_mode [0:L-1][0:M-1];
  logic          w_vld  [0:L-1][0:M-1];

  // Next-state values for levels 1..L.
  logic [W-1:0]  w_nval  [1:L][0:N-1];
  logic [IW-1:0] w_nidx  [1:L][0:N-1];
  logic          w_nmode [1:L][0:N-1];
  logic          w_nvld  [1:L][0:N-1];

  always_comb begin
    for (int l = 0; l < L; l++) begin
      for (int j = 0; j < M; j++) begin
        w_val[l][j]  = '0;
        w_idx[l][j]  = '0;
        w_mode[l][j] = 1'b0;
        w_vld[l][j]  = 1'b0;
      end
    end
    for (int j = 0; j < N; j++) begin
      w_val[0][j]  = io_inputs[j*W +: W];
      w_idx[0][j]  = IW'(j);
      w_mode[0][j] = io_mode;
      w_vld[0][j]  = io_in_valid;
    end
    for (int l = 1; l < L; l++) begin
      for (int j = 0; j < N; j++) begin
        w_val[l][j]  = r_val[l][j];
        w_idx[l][j]  = r_idx[l][j];
        w_mode[l][j] = r_mode[l][j];
        w_vld[l][j]  = r_vld[l][j];
      end
    end
  end

  always_comb begin
    for (int l = 1; l <= L; l++) begin
      for (int j = 0; j < N; j++) begin
        w_nval[l][j]  = '0;
        w_nidx[l][j]  = '0;
        w_nmode[l][j] = 1'b0;
        w_nvld[l][j]  = 1'b0;
        if (2*j + 1 < cnt_at(l-1)) begin
          // Right element wins only on a strict improvement; ties keep left.
          if (w_mode[l-1][2*j] ? (w_val[l-1][2*j+1] > w_val[l-1][2*j])
                               : (w_val[l-1][2*j+1] < w_val[l-1][2*j])) begin
            w_nval[l][j] = w_val[l-1][2*j+1];
            w_nidx[l][j] = w_idx[l-1][2*j+1];
          end else begin
            w_nval[l][j] = w_val[l-1][2*j];
            w_nidx[l][j] = w_idx[l-1][2*j];
          end
          w_nmode[l][j] = w_mode[l-1][2*j];
          w_nvld[l][j]  = w_vld[l-1][2*j];
        end else if (2*j < cnt_at(l-1)) begin
          // Odd leftover: registered pass-through.
          w_nval[l][j]  = w_val[l-1][2*j];
          w_nidx[l][j]  = w_idx[l-1][2*j];
          w_nmode[l][j] = w_mode[l-1][2*j];
          w_nvld[l][j]  = w_vld[l-1][2*j];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int l = 1; l <= L; l++) begin
        for (int j = 0; j < N; j++) begin
          r_val[l][j]  <= '0;
          r_idx[l][j]  <= '0;
          r_mode[l][j] <= 1'b0;
          r_vld[l][j]  <= 1'b0;
        end
      end
    end else if (io_start) begin
      for (int l = 1; l <= L; l++) begin
        for (int j = 0; j < N; j++) begin
          r_val[l][j]  <= w_nval[l][j];
          r_idx[l][j]  <= w_nidx[l][j];
          r_mode[l][j] <= w_nmode[l][j];
          r_vld[l][j]  <= w_nvld[l][j];
        end
      end
    end
  end

  assign io_result    = r_val[L][0];
  assign io_index     = r_idx[L][0];
  assign io_mode_out  = r_mode[L][0];
  assign io_out_valid = r_vld[L][0];

endmodule
